// File: rtl/mem_port_arb.sv
// rtl/mem_port_arb.sv - data-RAM port arbiter: p0 priority with p1 anti-starvation,
// read-return routing to the issuing port, and the LL/SC reservation bit.
module mem_port_arb #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                p0_req,
  input  logic                p0_we,
  input  logic                p0_ll,
  input  logic                p0_sc,
  input  logic [ADDR_W-1:0]   p0_addr,
  input  logic [DATA_W/8-1:0] p0_sel,
  input  logic [DATA_W-1:0]   p0_wdata,
  output logic                p0_gnt,
  output logic                p0_rvalid,
  output logic [DATA_W-1:0]   p0_rdata,
  input  logic                p1_req,
  input  logic                p1_we,
  input  logic [ADDR_W-1:0]   p1_addr,
  input  logic [DATA_W/8-1:0] p1_sel,
  input  logic [DATA_W-1:0]   p1_wdata,
  output logic                p1_gnt,
  output logic                p1_rvalid,
  output logic [DATA_W-1:0]   p1_rdata,
  input  logic                ll_clr_i,
  output logic                llbit_o,
  output logic                mem_ce_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W/8-1:0] mem_sel_o,
  output logic [DATA_W-1:0]   mem_data_o,
  input  logic [DATA_W-1:0]   mem_data_i
);

  localparam int                WA_W       = ADDR_W - 2;
  localparam logic [3:0]        MAX_WAIT_C = 4'(MAX_WAIT);
  localparam logic [ADDR_W-1:0] WORD_MASK  = ~ADDR_W'(3);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_e;

  owner_e          rd_owner_q, rd_owner_d;
  logic [3:0]      wait_cnt_q, wait_cnt_d;
  logic            llbit_q, llbit_d;
  logic [WA_W-1:0] ll_addr_q, ll_addr_d;

  logic p0_win, p1_win;
  logic p0_wr;
  logic sc_fail;
  logic p1_hits_resv;

  // An SC is always a write on the RAM side, even if the core left p0_we low.
  assign p0_wr        = p0_we | p0_sc;
  assign sc_fail      = p0_win & p0_sc & ~llbit_q;
  assign p1_hits_resv = (p1_addr[ADDR_W-1:2] == ll_addr_q);

  always_comb begin
    p0_win = 1'b0;
    p1_win = 1'b0;
    if (!rst) begin
      p1_win = p1_req && ((wait_cnt_q == MAX_WAIT_C) || !p0_req);
      p0_win = p0_req && !p1_win;
    end
  end

  assign p0_gnt  = p0_win;
  assign p1_gnt  = p1_win;
  assign llbit_o = llbit_q;

  always_comb begin
    mem_ce_o   = 1'b0;
    mem_we_o   = 1'b0;
    mem_addr_o = '0;
    mem_sel_o  = '0;
    mem_data_o = '0;
    if (p0_win) begin
      mem_ce_o   = ~sc_fail;
      mem_we_o   = p0_wr & ~sc_fail;
      mem_addr_o = p0_addr & WORD_MASK;
      mem_sel_o  = p0_sel;
      mem_data_o = p0_wdata;
    end else if (p1_win) begin
      mem_ce_o   = 1'b1;
      mem_we_o   = p1_we;
      mem_addr_o = p1_addr & WORD_MASK;
      mem_sel_o  = p1_sel;
      mem_data_o = p1_wdata;
    end
  end

  // Read data is steered by the owner tag registered at the grant edge.
  always_comb begin
    p0_rvalid = 1'b0;
    p1_rvalid = 1'b0;
    p0_rdata  = '0;
    p1_rdata  = '0;
    if (!rst) begin
      if (rd_owner_q == OWN_P0) begin
        p0_rvalid = 1'b1;
        p0_rdata  = mem_data_i;
      end else if (rd_owner_q == OWN_P1) begin
        p1_rvalid = 1'b1;
        p1_rdata  = mem_data_i;
      end
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!p1_req || p1_win) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q < MAX_WAIT_C) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  always_comb begin
    rd_owner_d = OWN_NONE;
    if (p0_win && !p0_wr) begin
      rd_owner_d = OWN_P0;
    end else if (p1_win && !p1_we) begin
      rd_owner_d = OWN_P1;
    end
  end

  // Clears are applied first so that a granted LL in the same cycle overrides them.
  always_comb begin
    llbit_d   = llbit_q;
    ll_addr_d = ll_addr_q;
    if (ll_clr_i) begin
      llbit_d = 1'b0;
    end
    if (p0_win && p0_sc) begin
      llbit_d = 1'b0;
    end
    if (p1_win && p1_we && p1_hits_resv) begin
      llbit_d = 1'b0;
    end
    if (p0_win && p0_ll) begin
      llbit_d   = 1'b1;
      ll_addr_d = p0_addr[ADDR_W-1:2];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= 4'd0;
      rd_owner_q <= OWN_NONE;
      llbit_q    <= 1'b0;
      ll_addr_q  <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      rd_owner_q <= rd_owner_d;
      llbit_q    <= llbit_d;
      ll_addr_q  <= ll_addr_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arb.sv
// tb/tb_mem_port_arb.sv - self-checking bench for mem_port_arb: directed scenarios
// followed by random traffic, all cycles compared against a behavioural model.
module tb_mem_port_arb;

  localparam int MAX_WAIT = 4;

  logic        clk;
  logic        rst;
  logic        p0_req, p0_we, p0_ll, p0_sc;
  logic [31:0] p0_addr, p0_wdata, p0_rdata;
  logic [3:0]  p0_sel;
  logic        p0_gnt, p0_rvalid;
  logic        p1_req, p1_we;
  logic [31:0] p1_addr, p1_wdata, p1_rdata;
  logic [3:0]  p1_sel;
  logic        p1_gnt, p1_rvalid;
  logic        ll_clr_i, llbit_o;
  logic        mem_ce_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_data_o, mem_data_i;
  logic [3:0]  mem_sel_o;

  mem_port_arb #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_ll(p0_ll), .p0_sc(p0_sc),
    .p0_addr(p0_addr), .p0_sel(p0_sel), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_sel(p1_sel),
    .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .ll_clr_i(ll_clr_i), .llbit_o(llbit_o),
    .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_sel_o(mem_sel_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // Reference model: owner 0=none 1=p0 2=p1, reservation as a word number.
  int          m_wait  = 0;
  int          m_owner = 0;
  bit          m_ll    = 1'b0;
  logic [31:0] m_lla   = '0;
  bit          g0      = 1'b0;
  bit          g1      = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ev();
    logic [31:0] e_addr, e_data, e_r0, e_r1;
    logic [3:0]  e_sel;
    logic        e_ce, e_we, e_v0, e_v1;
    @(negedge clk);
    g0 = 1'b0;
    g1 = 1'b0;
    if (!rst) begin
      g1 = p1_req && (m_wait >= MAX_WAIT || !p0_req);
      g0 = p0_req && !g1;
    end
    e_ce = 1'b0; e_we = 1'b0; e_addr = '0; e_sel = '0; e_data = '0;
    if (g0) begin
      e_ce   = !(p0_sc && !m_ll);
      e_we   = e_ce && (p0_we || p0_sc);
      e_addr = p0_addr & 32'hFFFF_FFFC;
      e_sel  = p0_sel;
      e_data = p0_wdata;
    end else if (g1) begin
      e_ce   = 1'b1;
      e_we   = p1_we;
      e_addr = p1_addr & 32'hFFFF_FFFC;
      e_sel  = p1_sel;
      e_data = p1_wdata;
    end
    e_v0 = !rst && m_owner == 1;
    e_v1 = !rst && m_owner == 2;
    e_r0 = e_v0 ? mem_data_i : 32'h0;
    e_r1 = e_v1 ? mem_data_i : 32'h0;
    chk("p0_gnt", p0_gnt, g0);
    chk("p1_gnt", p1_gnt, g1);
    chk("mem_ce", mem_ce_o, e_ce);
    chk("mem_we", mem_we_o, e_we);
    chk("mem_addr", mem_addr_o, e_addr);
    chk("mem_sel", mem_sel_o, e_sel);
    chk("mem_data", mem_data_o, e_data);
    chk("p0_rvalid", p0_rvalid, e_v0);
    chk("p1_rvalid", p1_rvalid, e_v1);
    chk("p0_rdata", p0_rdata, e_r0);
    chk("p1_rdata", p1_rdata, e_r1);
    chk("llbit", llbit_o, m_ll);
  endtask

  task automatic tk();
    bit nl;
    @(posedge clk);
    if (rst) begin
      m_wait = 0; m_owner = 0; m_ll = 1'b0; m_lla = '0;
    end else begin
      if (!p1_req || g1) m_wait = 0;
      else if (m_wait < MAX_WAIT) m_wait++;
      if (g0 && !(p0_we || p0_sc)) m_owner = 1;
      else if (g1 && !p1_we) m_owner = 2;
      else m_owner = 0;
      nl = m_ll;
      if (ll_clr_i) nl = 1'b0;
      if (g0 && p0_sc) nl = 1'b0;
      if (g1 && p1_we && (p1_addr >> 2) == m_lla) nl = 1'b0;
      if (g0 && p0_ll) begin
        nl = 1'b1;
        m_lla = p0_addr >> 2;
      end
      m_ll = nl;
    end
    #1;
  endtask

  task automatic p0_set(input logic req, input logic we, input logic ll, input logic sc,
                        input logic [31:0] addr);
    p0_req = req; p0_we = we; p0_ll = ll; p0_sc = sc; p0_addr = addr;
    p0_sel = 4'hF; p0_wdata = $urandom;
  endtask

  task automatic p1_set(input logic req, input logic we, input logic [31:0] addr);
    p1_req = req; p1_we = we; p1_addr = addr; p1_sel = 4'($urandom); p1_wdata = $urandom;
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] a;
    case ($urandom_range(0, 3))
      0: a = 32'h200;
      1: a = 32'h204;
      2: a = 32'h100;
      default: a = $urandom & 32'h0000_0FFC;
    endcase
    return a | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    rst = 1'b1; ll_clr_i = 1'b0; mem_data_i = '0;
    p0_set(1'b1, 1'b0, 1'b0, 1'b0, 32'h10);
    p1_set(1'b1, 1'b0, 32'h20);
    tk();

    // reset with both ports requesting
    for (int i = 0; i < 3; i++) begin
      ev();
      chk("rst_p0_gnt", p0_gnt, 1'b0);
      chk("rst_p1_gnt", p1_gnt, 1'b0);
      chk("rst_ce", mem_ce_o, 1'b0);
      chk("rst_llbit", llbit_o, 1'b0);
      tk();
    end
    rst = 1'b0;
    ev(); chk("rel_p0_gnt", p0_gnt, 1'b1); tk();
    p0_req = 1'b0; p1_req = 1'b0;
    ev(); tk();

    // single read return
    p0_set(1'b1, 1'b0, 1'b0, 1'b0, 32'h104);
    ev(); chk("rd_addr", mem_addr_o, 32'h104); chk("rd_gnt", p0_gnt, 1'b1); tk();
    p0_req = 1'b0; mem_data_i = 32'hDEAD_BEEF;
    ev();
    chk("rd_rvalid", p0_rvalid, 1'b1);
    chk("rd_rdata", p0_rdata, 32'hDEAD_BEEF);
    chk("rd_p1_rvalid", p1_rvalid, 1'b0);
    tk();

    // back-to-back reads alternating ports
    for (int i = 0; i < 6; i++) begin
      p0_set(i % 2 == 0, 1'b0, 1'b0, 1'b0, 32'h300 + 32'(i * 4));
      p1_set(i % 2 == 1, 1'b0, 32'h400 + 32'(i * 4));
      mem_data_i = $urandom;
      ev();
      if (i > 0) begin
        chk("b2b_p0_rvalid", p0_rvalid, (i % 2 == 1));
        chk("b2b_p1_rvalid", p1_rvalid, (i % 2 == 0));
      end
      tk();
    end
    p0_req = 1'b0; p1_req = 1'b0;
    ev(); tk();

    // starvation: p1 forced through at cycle MAX_WAIT
    p0_set(1'b1, 1'b0, 1'b0, 1'b0, 32'h40);
    p1_set(1'b1, 1'b0, 32'h80);
    for (int c = 0; c < 7; c++) begin
      mem_data_i = $urandom;
      ev();
      chk("starve_p1_gnt", p1_gnt, (c == MAX_WAIT));
      chk("starve_p0_gnt", p0_gnt, (c != MAX_WAIT));
      if (c == MAX_WAIT + 1) chk("starve_wait_clr", 64'(dut.wait_cnt_q), 64'd0);
      tk();
      if (c == MAX_WAIT) p1_req = 1'b0;
    end
    p0_req = 1'b0;
    ev(); tk();

    // LL/SC success
    p0_set(1'b1, 1'b0, 1'b1, 1'b0, 32'h200);
    ev(); tk();
    p0_req = 1'b0; p0_ll = 1'b0;
    ev(); chk("ll_set", llbit_o, 1'b1); tk();
    p0_set(1'b1, 1'b1, 1'b0, 1'b1, 32'h200);
    ev(); chk("sc_we", mem_we_o, 1'b1); chk("sc_ce", mem_ce_o, 1'b1); tk();
    p0_req = 1'b0; p0_sc = 1'b0;
    ev(); chk("sc_clr", llbit_o, 1'b0); tk();

    // reservation broken by a p1 write to the same word
    p0_set(1'b1, 1'b0, 1'b1, 1'b0, 32'h200);
    ev(); tk();
    p0_req = 1'b0; p0_ll = 1'b0;
    p1_set(1'b1, 1'b1, 32'h203);
    ev(); chk("brk_p1_gnt", p1_gnt, 1'b1); tk();
    p1_req = 1'b0;
    ev(); chk("brk_llbit", llbit_o, 1'b0); tk();
    p0_set(1'b1, 1'b1, 1'b0, 1'b1, 32'h200);
    ev(); chk("sc_fail_ce", mem_ce_o, 1'b0); chk("sc_fail_we", mem_we_o, 1'b0); tk();

    // p1 write to a different word keeps the reservation
    p0_set(1'b1, 1'b0, 1'b1, 1'b0, 32'h200);
    ev(); tk();
    p0_req = 1'b0; p0_ll = 1'b0;
    p1_set(1'b1, 1'b1, 32'h204);
    ev(); tk();
    p1_req = 1'b0;
    ev(); chk("keep_llbit", llbit_o, 1'b1); tk();

    // ll_clr_i clears; simultaneous LL and clear keeps the set
    ll_clr_i = 1'b1;
    ev(); tk();
    ll_clr_i = 1'b0;
    ev(); chk("llclr", llbit_o, 1'b0); tk();
    p0_set(1'b1, 1'b0, 1'b1, 1'b0, 32'h500);
    ll_clr_i = 1'b1;
    ev(); tk();
    p0_req = 1'b0; p0_ll = 1'b0; ll_clr_i = 1'b0;
    ev(); chk("set_wins", llbit_o, 1'b1); tk();

    // reset while a p1 read is outstanding
    p1_set(1'b1, 1'b0, 32'h600);
    ev(); chk("mid_p1_gnt", p1_gnt, 1'b1); tk();
    p1_req = 1'b0; rst = 1'b1;
    ev(); chk("mid_rvalid_rst", p1_rvalid, 1'b0); tk();
    rst = 1'b0;
    ev();
    chk("mid_rvalid_after", p1_rvalid, 1'b0);
    chk("mid_owner_none", 64'(dut.rd_owner_q), 64'd0);
    tk();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: p0_set($urandom_range(0, 9) < 7, 1'b0, 1'b0, 1'b0, pick_addr());
        1: p0_set($urandom_range(0, 9) < 7, 1'b1, 1'b0, 1'b0, pick_addr());
        2: p0_set($urandom_range(0, 9) < 7, 1'b0, 1'b1, 1'b0, pick_addr());
        default: p0_set($urandom_range(0, 9) < 7, 1'b1, 1'b0, 1'b1, pick_addr());
      endcase
      p0_sel = 4'($urandom);
      p1_set($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, pick_addr());
      ll_clr_i   = ($urandom_range(0, 19) == 0);
      rst        = ($urandom_range(0, 49) == 0);
      mem_data_i = $urandom;
      ev();
      tk();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
